seg7_output_display: RTL
========================

// Module: seg7_output_display
// PURPOSE
// - Consumes the CPU's 8-bit output register and shows it as unsigned decimal (0..255) on a 4-digit multiplexed 7-seg display.
// - Binary value converted to 3 BCD digits by a sequential double-dabble engine (one shift per cycle).
// - Digits then time-multiplexed onto shared segment lines; sits directly downstream of the CPU core's output register.
// PARAMETERS
// - REFRESH_DIV  1000  clk cycles each digit stays enabled; legal range >= 2
// - BLANK_LZ     1     1 = blank leading zeros (hundreds, tens); 0 = always show 3 digits
// PORTS
// - clk        in   1   system clock; the only clock
// - rst_n      in   1   reset, asynchronous assert, active-low
// - value      in   8   binary value from CPU output register; may change on any clk edge
// - seg        out  7   segments {g,f,e,d,c,b,a}, active-low, registered
// - an         out  4   digit enables, active-low, registered; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3] always 1
// - bcd        out  12  {hundreds,tens,ones} of last completed conversion, registered
// - busy       out  1   1 while conversion in progress (SHIFT or LOAD state)
// - conv_done  out  1   1-cycle pulse in the cycle after bcd updates
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, last_val=0, bcd=0, busy=0, conv_done=0, scan counter=0, digit index=0, seg=7'h7F, an=4'hF.
// - FSM IDLE: if value != last_val at clk edge T: latch value into scratch {h,t,o,bin}={4'h0,4'h0,4'h0,value}, last_val<=value, go SHIFT, shift count=0.
// - FSM SHIFT (exactly 8 cycles, T+1..T+8): per cycle, each BCD nibble >=5 gets +3, then whole 20-bit scratch shifts left 1.
// - FSM LOAD (T+9): bcd<=scratch[19:8]; go IDLE. bcd visible from T+10; conv_done=1 during T+10 only.
// - busy=1 from T+1 through T+9 (SHIFT and LOAD); 0 otherwise.
// - value changes while busy are ignored; upon return to IDLE, value re-compared against last_val, new conversion starts if different.
// - value equal to last_val in IDLE: no conversion; no new conversion on unchanged value after reset (value=0 shows "0").
// - Scan: free-running counter 0..REFRESH_DIV-1 independent of FSM; on wrap digit index steps 0->1->2->0.
// - Display regs: seg/an register from digit index and bcd each cycle; one cycle lag; first valid output cycle after reset release: an=4'b1110, seg=7'h40.
// - Decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10; blank=7F.
// - Blanking (BLANK_LZ=1): hundreds blank if h==0; tens blank if h==0 && t==0; ones never blank. Blank digit still gets its an slot, seg=7F.
// - BCD nibbles never exceed 9 (input max 255); nibble codes 10-15 unreachable, decode to 7F.
// - Digit change on scan wrap: an and seg update in same cycle (no ghosting cycle required beyond that).
// - Reset mid-conversion: FSM aborts to IDLE, bcd=0, conv_done not pulsed; post-reset, nonzero value triggers fresh conversion.
// TESTING
// - Reset, value=0, REFRESH_DIV=4 -> seg=7F/an=F in reset; then an cycles 1110,1101,1011 every 4 clks; seg 40,7F,7F.
// - value 0->255 at edge T -> busy T+1..T+9, bcd=12'h255 at T+10, conv_done pulse T+10, digits show 2,5,5 (seg 24,12,12).
// - value=7, BLANK_LZ=1 -> bcd=12'h007, seg: ones=78, tens=7F, hundreds=7F; BLANK_LZ=0 -> 78,40,40.
// - value=100 then 105 at T+3 (mid-conversion) -> first bcd=12'h100 at T+10, second conversion starts T+10 -> bcd=12'h105 at T+20.
// - rst_n low at T+5 during 200 conversion -> immediate seg=7F, an=F, bcd=0, busy=0; release with value=200 -> bcd=12'h200 after 10 cycles.
// - Exhaustive: sweep value 0..255, wait conv_done each -> bcd matches reference decimal, no conv_done on repeated equal value.

Source files
------------

// File: rtl/seg7_output_display.sv
// Shows the CPU's 8-bit output register as unsigned decimal on a 4-digit multiplexed
// 7-segment display, using a sequential double-dabble converter and a round-robin digit scan.
module seg7_output_display #(
    parameter int REFRESH_DIV = 1000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  value,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        conv_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  last_val_reg;
    logic [19:0] scratch_reg;
    logic [19:0] scratch_adj;
    logic [2:0]  shift_cnt_reg;
    logic [11:0] bcd_reg;
    logic        conv_done_reg;
    logic        start_conv, shift_en, load_en;

    logic [CW-1:0] scan_cnt_reg;
    logic [1:0]    digit_idx_reg;
    logic [6:0]    seg_reg, seg_next;
    logic [3:0]    an_reg, an_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (value != last_val_reg) state_next = SHIFT;
            SHIFT:   if (shift_cnt_reg == 3'd7) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = (state_reg != IDLE);
        start_conv = (state_reg == IDLE) && (value != last_val_reg);
        shift_en   = (state_reg == SHIFT);
        load_en    = (state_reg == LOAD);
    end

    // Add-3 correction on each BCD nibble before the shift; the binary byte passes through.
    assign scratch_adj[7:0] = scratch_reg[7:0];
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = scratch_reg[8 + 4*gi +: 4];
            assign scratch_adj[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_val_reg  <= 8'h00;
            scratch_reg   <= 20'h0;
            shift_cnt_reg <= 3'd0;
            bcd_reg       <= 12'h000;
            conv_done_reg <= 1'b0;
        end else begin
            conv_done_reg <= load_en;
            if (start_conv) begin
                scratch_reg   <= {12'h000, value};
                last_val_reg  <= value;
                shift_cnt_reg <= 3'd0;
            end
            if (shift_en) begin
                scratch_reg   <= {scratch_adj[18:0], 1'b0};
                shift_cnt_reg <= shift_cnt_reg + 3'd1;
            end
            if (load_en) bcd_reg <= scratch_reg[19:8];
        end
    end

    // Free-running scan: each digit stays enabled for REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= 2'd0;
        end else if (scan_cnt_reg == CW'(REFRESH_DIV - 1)) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= (digit_idx_reg == 2'd2) ? 2'd0 : digit_idx_reg + 2'd1;
        end else begin
            scan_cnt_reg  <= scan_cnt_reg + CW'(1);
        end
    end

    always_comb begin
        an_next  = 4'hF;
        seg_next = 7'h7F;
        case (digit_idx_reg)
            2'd0: begin
                an_next  = 4'b1110;
                seg_next = seg_decode(bcd_reg[3:0]);
            end
            2'd1: begin
                an_next  = 4'b1101;
                seg_next = (BLANK_LZ && bcd_reg[11:8] == 4'd0 && bcd_reg[7:4] == 4'd0)
                           ? 7'h7F : seg_decode(bcd_reg[7:4]);
            end
            2'd2: begin
                an_next  = 4'b1011;
                seg_next = (BLANK_LZ && bcd_reg[11:8] == 4'd0) ? 7'h7F : seg_decode(bcd_reg[11:8]);
            end
            default: begin
                an_next  = 4'hF;
                seg_next = 7'h7F;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= 7'h7F;
            an_reg  <= 4'hF;
        end else begin
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign seg       = seg_reg;
    assign an        = an_reg;
    assign bcd       = bcd_reg;
    assign conv_done = conv_done_reg;

endmodule
